// File: rtl/restoring_divider_seq.sv
// Multi-cycle restoring divider: one trial subtract per clock, then keep or restore.
// Latency: WIDTH+1 cycles from the accepting edge to done (divide by zero: 1 cycle).
// Backpressure: none. start is ignored while busy and accepted in IDLE or DONE.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   start               request, sampled only when not busy
//   Dividend, Divisor   operands, captured on the accepting edge
//   busy                high while an iteration sequence is running
//   done                one-cycle pulse, results valid
//   Quotient, Remainder results, held until the next accepted operation completes
//   DivByZero           set alongside done when the divisor was zero
//
// Build option: define DIV_SIGNED_EN for two's-complement operands and results.
// The unsigned core then runs on magnitudes, and the signs are fixed up at DONE.
module restoring_divider_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             DivByZero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);
  localparam logic [WIDTH:0]   ONE_D = (WIDTH + 1)'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a, q, m;
  logic [CW-1:0]    count;

  logic             accept;
  logic             div_zero_in;
  logic             last_iter;
  logic [WIDTH-1:0] dd_mag, dv_mag;

  logic [2*WIDTH-1:0] aq_sh;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH:0]     d;
  logic [WIDTH-1:0]   a_nxt, q_nxt;
  logic [WIDTH-1:0]   q_res, r_res;

`ifdef DIV_SIGNED_EN
  logic sgn_dd, sgn_dv;

  // MIN maps onto itself, which is exactly its unsigned magnitude.
  assign dd_mag = Dividend[WIDTH-1] ? (~Dividend + ONE_W) : Dividend;
  assign dv_mag = Divisor[WIDTH-1]  ? (~Divisor + ONE_W)  : Divisor;
  assign q_res  = (sgn_dd ^ sgn_dv) ? (~q_nxt + ONE_W) : q_nxt;
  assign r_res  = sgn_dd ? (~a_nxt + ONE_W) : a_nxt;
`else
  assign dd_mag = Dividend;
  assign dv_mag = Divisor;
  assign q_res  = q_nxt;
  assign r_res  = a_nxt;
`endif

  assign accept      = start && (state == IDLE || state == DONE);
  assign div_zero_in = (Divisor == '0);
  assign last_iter   = (count == CW'(1));

  // One restoring step. A stays below 2^(WIDTH-1) before every shift, so the
  // shifted partial remainder always fits in WIDTH bits. The borrow of the
  // trial subtract appears only in d[WIDTH].
  always_comb begin
    aq_sh = {a, q} << 1;
    a_sh  = aq_sh[2*WIDTH-1:WIDTH];
    d     = {1'b0, a_sh} + ~{1'b0, m} + ONE_D;
    a_nxt = d[WIDTH] ? a_sh : d[WIDTH-1:0];
    // The bit shifted in at the bottom is zero, so OR-ing sets the quotient bit.
    q_nxt = aq_sh[WIDTH-1:0] | {{(WIDTH-1){1'b0}}, ~d[WIDTH]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = IDLE;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE, DONE: begin
        done = (state == DONE);
        if (start) state_nxt = div_zero_in ? DONE : RUN;
        else       state_nxt = IDLE;
      end
      RUN: begin
        busy      = 1'b1;
        state_nxt = last_iter ? DONE : RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a         <= '0;
      q         <= '0;
      m         <= '0;
      count     <= '0;
      Quotient  <= '0;
      Remainder <= '0;
      DivByZero <= 1'b0;
`ifdef DIV_SIGNED_EN
      sgn_dd    <= 1'b0;
      sgn_dv    <= 1'b0;
`endif
    end else if (accept) begin
      if (div_zero_in) begin
        // No iterations: results go straight out in the DONE cycle.
        Quotient  <= '1;
        Remainder <= Dividend;
        DivByZero <= 1'b1;
      end else begin
        a     <= '0;
        q     <= dd_mag;
        m     <= dv_mag;
        count <= CW'(WIDTH);
`ifdef DIV_SIGNED_EN
        sgn_dd <= Dividend[WIDTH-1];
        sgn_dv <= Divisor[WIDTH-1];
`endif
      end
    end else if (state == RUN) begin
      a     <= a_nxt;
      q     <= q_nxt;
      count <= count - CW'(1);
      if (last_iter) begin
        Quotient  <= q_res;
        Remainder <= r_res;
        DivByZero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_restoring_divider_seq.sv
module tb_restoring_divider_seq;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_tests = 0;
  int n_fail  = 0;

  restoring_divider_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .Dividend  (dividend),
    .Divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .Quotient  (quotient),
    .Remainder (remainder),
    .DivByZero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural reference: plain integer division on the operand values.
  task automatic ref_div(input logic [W-1:0] dd, input logic [W-1:0] dv,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic z);
`ifdef DIV_SIGNED_EN
    int sdd, sdv, qi, ri;
    sdd = dd[W-1] ? int'(dd) - (1 << W) : int'(dd);
    sdv = dv[W-1] ? int'(dv) - (1 << W) : int'(dv);
    if (sdv == 0) begin
      q = '1; r = dd; z = 1'b1;
    end else if (sdd == -(1 << (W-1)) && sdv == -1) begin
      q = dd; r = '0; z = 1'b0;
    end else begin
      qi = sdd / sdv;
      ri = sdd % sdv;
      q = qi[W-1:0]; r = ri[W-1:0]; z = 1'b0;
    end
`else
    if (dv == '0) begin
      q = '1; r = dd; z = 1'b1;
    end else begin
      q = dd / dv; r = dd % dv; z = 1'b0;
    end
`endif
  endtask

  // Issue one operation from a negedge; return at the negedge of the done
  // cycle (so a caller can start the next one back-to-back) or after a timeout.
  task automatic run_op(input logic [W-1:0] dd, input logic [W-1:0] dv,
                        output logic [W-1:0] q, output logic [W-1:0] r,
                        output logic z, output int nbusy, output int dcyc);
    start = 1'b1; dividend = dd; divisor = dv;
    @(posedge clk); #1;
    start = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    nbusy = 0; dcyc = -1; q = '0; r = '0; z = 1'b0;
    for (int k = 1; k <= 20 && dcyc < 0; k++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (done) begin
        dcyc = k; q = quotient; r = remainder; z = div_by_zero;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    #2;
    n_tests++;
    if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b required 0", {busy, done, quotient, remainder, div_by_zero});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %b required 0", {busy, done, quotient, remainder, div_by_zero});
    end
  endtask

  task automatic test_basic;
    logic [W-1:0] q, r; logic z; int nb, dc;
    run_op(4'd13, 4'd3, q, r, z, nb, dc);
    n_tests++;
    if ({q, r, z} !== {4'h4, 4'h1, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_13_3: got q=%h r=%h z=%b required q=4 r=1 z=0", q, r, z);
    end
    n_tests++;
    if (nb !== W || dc !== W + 1) begin
      n_fail++;
      $display("FAIL basic_latency: got busy=%0d done_at=%0d required %0d/%0d", nb, dc, W, W + 1);
    end
    @(negedge clk);
    n_tests++;
    if ({done, busy, quotient, remainder} !== {1'b0, 1'b0, 4'h4, 4'h1}) begin
      n_fail++;
      $display("FAIL basic_pulse_hold: got done=%b busy=%b q=%h r=%h required 0 0 4 1", done, busy, quotient, remainder);
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] q, r; logic z; int nb, dc;
    run_op(4'd15, 4'd1, q, r, z, nb, dc);
    n_tests++;
    if ({q, r, z} !== {4'hF, 4'h0, 1'b0} || dc !== W + 1) begin
      n_fail++;
      $display("FAIL b2b_first: got q=%h r=%h z=%b at %0d required q=f r=0 z=0 at %0d", q, r, z, dc, W + 1);
    end
    run_op(4'd2, 4'd5, q, r, z, nb, dc);
    n_tests++;
    if ({q, r, z} !== {4'h0, 4'h2, 1'b0} || dc !== W + 1 || nb !== W) begin
      n_fail++;
      $display("FAIL b2b_second: got q=%h r=%h z=%b busy=%0d at %0d required q=0 r=2 z=0", q, r, z, nb, dc);
    end
  endtask

  task automatic test_div_zero;
    logic [W-1:0] q, r; logic z; int nb, dc;
    @(negedge clk);
    run_op(4'd7, 4'd0, q, r, z, nb, dc);
    n_tests++;
    if ({q, r, z} !== {4'hF, 4'h7, 1'b1}) begin
      n_fail++;
      $display("FAIL div_zero_result: got q=%h r=%h z=%b required q=f r=7 z=1", q, r, z);
    end
    n_tests++;
    if (nb !== 0 || dc !== 1) begin
      n_fail++;
      $display("FAIL div_zero_latency: got busy=%0d done_at=%0d required 0/1", nb, dc);
    end
    @(negedge clk);
    n_tests++;
    if ({done, busy, div_by_zero} !== 3'b001) begin
      n_fail++;
      $display("FAIL div_zero_hold: got done=%b busy=%b z=%b required 0 0 1", done, busy, div_by_zero);
    end
  endtask

  task automatic test_busy_ignore;
    int dc;
    logic [W-1:0] q, r;
    start = 1'b1; dividend = 4'd9; divisor = 4'd2;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; dividend = 4'd1; divisor = 4'd1;
    @(posedge clk); #1;
    start = 1'b0;
    dc = -1; q = '0; r = '0;
    for (int k = 3; k <= 20 && dc < 0; k++) begin
      @(negedge clk);
      if (done) begin dc = k; q = quotient; r = remainder; end
    end
    n_tests++;
    if ({q, r} !== {4'h4, 4'h1} || dc !== W + 1) begin
      n_fail++;
      $display("FAIL busy_ignore_result: got q=%h r=%h at %0d required q=4 r=1 at %0d", q, r, dc, W + 1);
    end
    @(negedge clk);
    n_tests++;
    if ({busy, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL busy_ignore_no_queue: got busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_reset_mid;
    logic [W-1:0] q, r; logic z; int nb, dc;
    start = 1'b1; dividend = 4'd12; divisor = 4'd5;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_clear: got %b required 0", {busy, done, quotient, remainder, div_by_zero});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    n_tests++;
    if ({busy, done, quotient, remainder} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_idle: got %b required 0", {busy, done, quotient, remainder});
    end
    run_op(4'd12, 4'd5, q, r, z, nb, dc);
    n_tests++;
    if ({q, r, z} !== {4'h2, 4'h2, 1'b0} || dc !== W + 1) begin
      n_fail++;
      $display("FAIL reset_mid_rerun: got q=%h r=%h z=%b at %0d required q=2 r=2 z=0", q, r, z, dc);
    end
  endtask

  task automatic test_signed;
    logic [W-1:0] q, r; logic z; int nb, dc;
    @(negedge clk);
    run_op(4'b1001, 4'b0010, q, r, z, nb, dc);
    n_tests++;
    if ({q, r, z} !== {4'b1101, 4'b1111, 1'b0} || dc !== W + 1) begin
      n_fail++;
      $display("FAIL signed_m7_2: got q=%b r=%b z=%b at %0d required q=1101 r=1111 z=0", q, r, z, dc);
    end
    run_op(4'b1000, 4'b1111, q, r, z, nb, dc);
    n_tests++;
    if ({q, r, z} !== {4'b1000, 4'b0000, 1'b0}) begin
      n_fail++;
      $display("FAIL signed_min_m1: got q=%b r=%b z=%b required q=1000 r=0000 z=0", q, r, z);
    end
  endtask

  task automatic test_random;
    logic [W-1:0] dd, dv, q, r, eq, er;
    logic z, ez;
    int nb, dc;
    for (int i = 0; i < 60; i++) begin
      dd = W'($urandom);
      dv = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      ref_div(dd, dv, eq, er, ez);
      run_op(dd, dv, q, r, z, nb, dc);
      n_tests++;
      if ({q, r, z} !== {eq, er, ez}) begin
        n_fail++;
        $display("FAIL rand_result %0d (%h/%h): got q=%h r=%h z=%b required q=%h r=%h z=%b",
                 i, dd, dv, q, r, z, eq, er, ez);
      end
      n_tests++;
      if (dc !== (ez ? 1 : W + 1) || nb !== (ez ? 0 : W)) begin
        n_fail++;
        $display("FAIL rand_latency %0d: got busy=%0d done_at=%0d required %0d/%0d",
                 i, nb, dc, ez ? 0 : W, ez ? 1 : W + 1);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset;
`ifdef DIV_SIGNED_EN
    test_div_zero;
    test_signed;
`else
    test_basic;
    test_back_to_back;
    test_div_zero;
    test_busy_ignore;
    test_reset_mid;
`endif
    @(negedge clk);
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
